reg_file_param: RTL and testbench

//  - Parametrised general-purpose register file for the datapath.
//  - Two combinational read ports (source s, destination d) and one synchronous write port.
//  - Per-entry dirty tracking, and a hardware clear sequencer that restores every entry to RESET_VAL.
//  - Sits between the instruction decode (sr/dr/waddr) and the ALU operand/result buses.

---
 rtl/reg_file_pkg.sv | 18 +
 rtl/reg_clear_seq.sv | 63 ++++++
 rtl/reg_file_param.sv | 91 +++++++++
 tb/tb_reg_file_param.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types, default parameters and sizing helper for the reg_file_param register file.
package reg_file_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_e;

   localparam int DW_DEF        = 8;
   localparam int AW_DEF        = 2;
   localparam int RESET_VAL_DEF = 'h01;

   // Number of entries addressed by an AW-bit address.
   function automatic int depth(input int aw);
      return 1 << aw;
   endfunction

endpackage : reg_file_pkg

// File: rtl/reg_clear_seq.sv
// Clear sequencer: walks a pointer over every entry, one per cycle, and asks the
// register file to reload it with its reset value.
module reg_clear_seq
   import reg_file_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   output logic          busy,
   output logic          clr_we,
   output logic [AW-1:0] clr_addr
);

   localparam int            N    = depth(AW);
   localparam logic [AW-1:0] LAST = AW'(N - 1);

   state_e        state_q;
   logic [AW-1:0] ptr_q;
   logic          busy_q;

   // NOTE: every register below uses non-blocking assignment so all of them
   // update together from the values sampled at the same clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // Entry 0 is cleared on the start edge itself, so the walk resumes at 1.
               if (clr) begin
                  state_q <= CLEAR;
                  ptr_q   <= AW'(1);
                  busy_q  <= 1'b1;
               end
            end
            CLEAR: begin
               if (ptr_q == LAST) begin
                  state_q <= IDLE;
                  ptr_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  ptr_q <= ptr_q + AW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               ptr_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // The start edge must already clear entry 0, hence the IDLE && clr term.
   assign clr_we   = (state_q == CLEAR) || ((state_q == IDLE) && clr);
   assign clr_addr = ptr_q;
   assign busy     = busy_q;

endmodule : reg_clear_seq

// File: rtl/reg_file_param.sv
// Parametrised register file: two combinational read ports, one write port, dirty
// tracking and a hardware clear sweep. Optional forwarding via `REG_BYPASS_EN.
module reg_file_param
   import reg_file_pkg::*;
#(
   parameter int            DW        = DW_DEF,
   parameter int            AW        = AW_DEF,
   parameter logic [DW-1:0] RESET_VAL = DW'(RESET_VAL_DEF)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DW-1:0]         wdata,
   input  logic [AW-1:0]         sr,
   input  logic [AW-1:0]         dr,
   input  logic                  clr,
   output logic [DW-1:0]         s,
   output logic [DW-1:0]         d,
   output logic                  busy,
   output logic [depth(AW)-1:0]  dirty
);

   localparam int N = depth(AW);

   logic [DW-1:0] regs_q [N];
   logic [DW-1:0] regs_d [N];
   logic [N-1:0]  dirty_q;
   logic [N-1:0]  dirty_d;

   logic          clr_we;
   logic [AW-1:0] clr_addr;
   logic          user_we;

   reg_clear_seq #(
      .AW (AW)
   ) u_clear_seq (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   // A user write is accepted only in IDLE with no clear request pending.
   assign user_we = we && !busy && !clr;

   // NOTE: combinational next-state starts from a full default copy so no path
   // leaves a target unassigned and no latch is inferred.
   always_comb begin
      regs_d  = regs_q;
      dirty_d = dirty_q;
      if (clr_we) begin
         regs_d[clr_addr]  = RESET_VAL;
         dirty_d[clr_addr] = 1'b0;
      end else if (user_we) begin
         regs_d[waddr]  = wdata;
         dirty_d[waddr] = 1'b1;
      end
   end

   // NOTE: the storage is a small flop array, not a RAM macro, so every entry
   // takes the asynchronous reset value directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N; k++) begin
            regs_q[k] <= RESET_VAL;
         end
         dirty_q <= '0;
      end else begin
         regs_q  <= regs_d;
         dirty_q <= dirty_d;
      end
   end

`ifdef REG_BYPASS_EN
   always_comb begin
      s = (user_we && (waddr == sr)) ? wdata : regs_q[sr];
      d = (user_we && (waddr == dr)) ? wdata : regs_q[dr];
   end
`else
   always_comb begin
      s = regs_q[sr];
      d = regs_q[dr];
   end
`endif

   assign dirty = dirty_q;

endmodule : reg_file_param

// File: tb/tb_reg_file_param.sv
// Directed self-checking bench for reg_file_param (default DW=8, AW=2, RESET_VAL=8'h01).
module tb_reg_file_param;

   logic       clk;
   logic       rst_n;
   logic       we;
   logic [1:0] waddr;
   logic [7:0] wdata;
   logic [1:0] sr;
   logic [1:0] dr;
   logic       clr;
   logic [7:0] s;
   logic [7:0] d;
   logic       busy;
   logic [3:0] dirty;

   int n_cmp = 0;
   int n_err = 0;

   reg_file_param dut (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .sr    (sr),
      .dr    (dr),
      .clr   (clr),
      .s     (s),
      .d     (d),
      .busy  (busy),
      .dirty (dirty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_entry(input int idx, input logic [7:0] exp, input string tag);
      sr = 2'(idx);
      dr = 2'(idx);
      #1;
      check({tag, "_s"}, {24'b0, s}, {24'b0, exp});
      check({tag, "_d"}, {24'b0, d}, {24'b0, exp});
   endtask

   task automatic write_entry(input int idx, input logic [7:0] val);
      we    = 1'b1;
      waddr = 2'(idx);
      wdata = val;
      tick();
      we    = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      we    = 1'b0;
      waddr = '0;
      wdata = '0;
      sr    = '0;
      dr    = '0;
      clr   = 1'b0;

      // 1. Reset state
      #2;
      check("rst_busy_during", {31'b0, busy}, 32'd0);
      #10;
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         sr = 2'(i);
         dr = 2'(3 - i);
         #1;
         check($sformatf("rst_s%0d", i), {24'b0, s}, 32'h01);
         check($sformatf("rst_d%0d", 3 - i), {24'b0, d}, 32'h01);
      end
      check("rst_dirty", {28'b0, dirty}, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'd0);

      // 2. Single write, both read ports on the same address
      write_entry(2, 8'hA5);
      read_entry(2, 8'hA5, "wr2");
      check("wr2_dirty", {28'b0, dirty}, 32'h4);
      read_entry(0, 8'h01, "wr2_e0");
      read_entry(1, 8'h01, "wr2_e1");
      read_entry(3, 8'h01, "wr2_e3");

      // 3. Fill, then sweep with writes and a second clr attempted while busy
      for (int i = 0; i < 4; i++) write_entry(i, 8'h10 + 8'(i));
      for (int i = 0; i < 4; i++) read_entry(i, 8'h10 + 8'(i), $sformatf("fill%0d", i));
      check("fill_dirty", {28'b0, dirty}, 32'hF);
      clr = 1'b1;
      tick();                                   // edge 1: entry 0 cleared
      clr   = 1'b0;
      we    = 1'b1;
      waddr = 2'd3;
      wdata = 8'hFF;
      check("sw_busy1", {31'b0, busy}, 32'd1);
      check("sw_dirty1", {28'b0, dirty}, 32'hE);
      tick();                                   // edge 2: entry 1 cleared
      check("sw_busy2", {31'b0, busy}, 32'd1);
      read_entry(1, 8'h01, "sw_part1");
      read_entry(2, 8'h12, "sw_part2");
      clr = 1'b1;
      tick();                                   // edge 3: entry 2 cleared, clr ignored
      clr = 1'b0;
      check("sw_busy3", {31'b0, busy}, 32'd1);
      tick();                                   // edge 4: entry 3 cleared, back to IDLE
      we = 1'b0;
      check("sw_busy4", {31'b0, busy}, 32'd0);
      for (int i = 0; i < 4; i++) read_entry(i, 8'h01, $sformatf("sw_end%0d", i));
      check("sw_dirty_end", {28'b0, dirty}, 32'h0);
      tick();
      check("sw_no_restart", {31'b0, busy}, 32'd0);

      // 4. clr and we in the same IDLE cycle: write dropped
      clr   = 1'b1;
      we    = 1'b1;
      waddr = 2'd1;
      wdata = 8'h55;
      tick();
      clr = 1'b0;
      we  = 1'b0;
      read_entry(1, 8'h01, "cw_e1");
      check("cw_dirty", {28'b0, dirty}, 32'h0);
      tick();
      tick();
      tick();
      check("cw_busy_end", {31'b0, busy}, 32'd0);

      // 5. Reset in the middle of a sweep
      for (int i = 0; i < 4; i++) write_entry(i, 8'h20 + 8'(i));
      check("mr_dirty_pre", {28'b0, dirty}, 32'hF);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      tick();
      check("mr_busy_pre", {31'b0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("mr_busy_rst", {31'b0, busy}, 32'd0);
      check("mr_dirty_rst", {28'b0, dirty}, 32'h0);
      for (int i = 0; i < 4; i++) read_entry(i, 8'h01, $sformatf("mr_e%0d", i));
      #2;
      rst_n = 1'b1;
      tick();
      write_entry(2, 8'h66);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("mr_idle%0d", i), {31'b0, busy}, 32'd0);
         tick();
      end
      read_entry(2, 8'h66, "mr_keep2");
      check("mr_dirty_post", {28'b0, dirty}, 32'h4);

      // 6. Write-to-read forwarding (build dependent)
      write_entry(1, 8'h44);
      sr    = 2'd1;
      dr    = 2'd0;
      we    = 1'b1;
      waddr = 2'd1;
      wdata = 8'h3C;
      #1;
`ifdef REG_BYPASS_EN
      check("byp_s_same", {24'b0, s}, 32'h3C);
`else
      check("byp_s_same", {24'b0, s}, 32'h44);
`endif
      check("byp_d_other", {24'b0, d}, 32'h01);
      tick();
      we = 1'b0;
      #1;
      check("byp_s_after", {24'b0, s}, 32'h3C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_reg_file_param
